ltc_spi_responder: RTL
======================

// Module: ltc_spi_responder
// PURPOSE
//  SPI mode-0 slave speaking the LTC2986 framing: instruction byte, 16-bit address, N data bytes, MSB first.
//  Backed by a 2^MEM_AW-byte register RAM that the fabric can also write and read.
//  Sits on the board-side SPI pins as a stand-in LTC2986, so the SPI master and its sequencer can be exercised in hardware.
//  Also lets an external host read the temperature results.
// PARAMETERS
//  MEM_AW    6    RAM address width; 64 bytes; SPI address bits [15:MEM_AW] are ignored
//  SYNC_FF   2    synchroniser depth on spi_sck/spi_mosi/spi_cs; legal values 2..3
// PORTS
//  clk        in   1       system clock; SCK half-period must be >= 4 clk
//  reset      in   1       synchronous, active-high
//  spi_sck    in   1       SPI clock from master, idle low
//  spi_mosi   in   1       master data; sampled on SCK rising edge
//  spi_cs     in   1       chip select, active low
//  spi_miso   out  1       slave data; updated on SCK falling edge
//  usr_we     in   1       fabric write strobe
//  usr_addr   in   MEM_AW  fabric read/write address
//  usr_wdata  in   8       fabric write data
//  usr_rdata  out  8       mem[usr_addr]; 1-clk latency; updated every clk
//  wr_valid   out  1       1-clk pulse when an SPI data byte is committed
//  wr_addr    out  MEM_AW  address of the committed byte
//  wr_data    out  8       value of the committed byte
//  busy       out  1       high while the synchronised CS is low and a frame is active
//  frame_err  out  1       1-clk pulse when CS rises with a partial byte pending
// BEHAVIOUR
//  Reset values: spi_miso=0, usr_rdata=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, frame_err=0, state=IDLE.
//  RAM contents are not reset.
//  Inputs pass through SYNC_FF flops; sck_rise/sck_fall/cs_fall/cs_rise are detected from the last two sync stages.
//  States:
//   - IDLE: wait for cs_fall -> INSTR; bit count=0.
//   - INSTR: 0x02 -> ADDR_H (write); 0x03 -> ADDR_H (read); other -> IGNORE.
//   - ADDR_H, ADDR_L: shift in address; after ADDR_L, addr <= {ADDR_H,ADDR_L}[MEM_AW-1:0] -> DATA.
//   - DATA: runs until cs_rise.
//   - IGNORE: MISO held 0 until cs_rise.
//  Shift-in: on each sck_rise, rx <= {rx[6:0],mosi} and bit count+1; the byte completes on the 8th rise.
//  Write frame:
//   - On data byte complete, mem[addr] <= rx.
//   - wr_valid=1 with wr_addr=addr, wr_data=rx, 1 clk after the 8th rise; then addr+1.
//  Read frame:
//   - On ADDR_L complete (and on each data byte complete), tx <= mem[addr]; addr+1.
//   - On every sck_fall in DATA, spi_miso <= next tx bit, MSB first.
//   - The first sck_fall after the load drives tx[7]. Bit 7 is valid >= 2 clk before the master's next rising edge.
//  spi_miso=0 in IDLE, INSTR, ADDR_H, ADDR_L and IGNORE, and whenever CS is high.
//  Address wrap: addr = 2^MEM_AW-1 increments to 0.
//  Collision: usr_we and an SPI commit to the same address in the same clk -> SPI value wins; usr write is dropped.
//  cs_rise at any bit:
//   - -> IDLE, busy=0; partial byte discarded, not written.
//   - frame_err pulses if bit count != 0.
//   - cs_rise and the 8th sck_rise in the same clk: the byte commits first, then IDLE.
//  Reset mid-frame: -> IDLE; a CS already low at reset release is ignored until a new cs_fall.
//  sck edges while CS is high are ignored.
// CONFIGURATION
//  SPI_RESP_AUTOINC_EN defined: addr increments after every data byte, as above (burst access).
//  Not defined: addr is fixed for the whole frame; every data byte of a read returns mem[addr];
//  every data byte of a write overwrites mem[addr], and wr_valid pulses per byte.
// TESTING
//  1. Preload usr mem[0x10..0x13]=A1,B2,C3,D4; SPI read 03 00 10 + 4 dummy bytes -> master rx = A1,B2,C3,D4 (AUTOINC_EN).
//  2. SPI write 02 02 3F 5A 66 with MEM_AW=6 -> wr_valid twice: (0x3F,5A) then (0x00,66); usr_rdata@0x3F=5A, @0x00=66.
//  3. Instruction 0x07 then 3 bytes -> no wr_valid, MISO stays 0, busy high until CS rises.
//  4. CS rises after 5 bits of a write data byte -> frame_err 1 pulse; mem unchanged; next frame decodes normally.
//  5. usr_we to 0x05 in the same clk as an SPI commit of 0x99 to 0x05 -> mem[0x05]=0x99.
//  6. reset asserted mid read frame, CS held low -> all outputs at reset values; no response until CS toggles high then low.

Source files
------------

// File: rtl/ltc_spi_responder.sv
// rtl/ltc_spi_responder.sv - LTC2986-framed SPI mode-0 responder over a fabric-shared register RAM.
// Define SPI_RESP_AUTOINC_EN for burst addressing; otherwise the address is fixed for the whole frame.
module ltc_spi_responder #(
  parameter int MEM_AW  = 6,
  parameter int SYNC_FF = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_spi_sck,
  input  logic              i_spi_mosi,
  input  logic              i_spi_cs,
  output logic              o_spi_miso,
  input  logic              i_usr_we,
  input  logic [MEM_AW-1:0] i_usr_addr,
  input  logic [7:0]        i_usr_wdata,
  output logic [7:0]        o_usr_rdata,
  output logic              o_wr_valid,
  output logic [MEM_AW-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_busy,
  output logic              o_frame_err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INSTR  = 3'd1;
  localparam logic [2:0] ST_ADDR_H = 3'd2;
  localparam logic [2:0] ST_ADDR_L = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam int DEPTH = 1 << MEM_AW;
`ifdef SPI_RESP_AUTOINC_EN
  localparam logic [MEM_AW-1:0] ADDR_STEP = {{(MEM_AW-1){1'b0}}, 1'b1};
`else
  localparam logic [MEM_AW-1:0] ADDR_STEP = '0;
`endif

  logic [7:0]        r_mem [DEPTH];

  logic [SYNC_FF-1:0] r_sck_sync;
  logic [SYNC_FF-1:0] r_mosi_sync;
  logic [SYNC_FF-1:0] r_cs_sync;
  logic              r_sck_prev;
  logic              r_cs_prev;

  logic [2:0]        r_state;
  logic [2:0]        r_bitcnt;
  logic [6:0]        r_rx;
  logic [7:0]        r_tx;
  logic              r_is_read;
  logic [MEM_AW-1:0] r_addr;
  logic              r_miso;
  logic [7:0]        r_usr_rdata;
  logic              r_wr_valid;
  logic [MEM_AW-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_frame_err;

  logic              w_sck;
  logic              w_mosi;
  logic              w_cs;
  logic              w_sck_rise;
  logic              w_sck_fall;
  logic              w_cs_rise;
  logic              w_cs_fall;
  logic [7:0]        w_byte;
  logic              w_byte_done;
  logic              w_commit;
  logic [2:0]        w_bitcnt_next;
  logic [MEM_AW-1:0] w_frame_addr;

  assign w_sck  = r_sck_sync[SYNC_FF-1];
  assign w_mosi = r_mosi_sync[SYNC_FF-1];
  assign w_cs   = r_cs_sync[SYNC_FF-1];

  always_comb begin
    w_sck_rise    = w_sck & ~r_sck_prev;
    w_sck_fall    = ~w_sck & r_sck_prev;
    w_cs_rise     = w_cs & ~r_cs_prev;
    w_cs_fall     = ~w_cs & r_cs_prev;
    w_byte        = {r_rx, w_mosi};
    w_byte_done   = (r_state != ST_IDLE) && w_sck_rise && (r_bitcnt == 3'd7);
    w_commit      = w_byte_done && (r_state == ST_DATA) && !r_is_read && !i_reset;
    w_bitcnt_next = w_sck_rise ? (r_bitcnt + 3'd1) : r_bitcnt;
  end

  // Only address bits below MEM_AW are kept; the upper instruction-address bits are don't-care.
  generate
    if (MEM_AW > 8) begin : g_wide_addr
      logic [MEM_AW-9:0] r_addr_h;
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          r_addr_h <= '0;
        end else if (w_byte_done && r_state == ST_ADDR_H) begin
          r_addr_h <= w_byte[MEM_AW-9:0];
        end
      end
      assign w_frame_addr = {r_addr_h, w_byte};
    end else begin : g_narrow_addr
      assign w_frame_addr = w_byte[MEM_AW-1:0];
    end
  endgenerate

  // SPI commit has priority over a fabric write to the same address.
  always_ff @(posedge i_clk) begin
    if (i_usr_we && !(w_commit && (i_usr_addr == r_addr))) begin
      r_mem[i_usr_addr] <= i_usr_wdata;
    end
    if (w_commit) begin
      r_mem[r_addr] <= w_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // CS sync cleared to "low" so a CS already low at release never looks like a new fall.
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '0;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_state     <= ST_IDLE;
      r_bitcnt    <= 3'd0;
      r_rx        <= 7'd0;
      r_tx        <= 8'd0;
      r_is_read   <= 1'b0;
      r_addr      <= '0;
      r_miso      <= 1'b0;
      r_usr_rdata <= 8'd0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 8'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_FF-2:0], i_spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_FF-2:0], i_spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_FF-2:0], i_spi_cs};
      r_sck_prev  <= w_sck;
      r_cs_prev   <= w_cs;
      r_usr_rdata <= r_mem[i_usr_addr];
      r_wr_valid  <= 1'b0;
      r_frame_err <= 1'b0;

      if (r_state == ST_IDLE) begin
        r_miso <= 1'b0;
        if (w_cs_fall) begin
          r_state  <= ST_INSTR;
          r_bitcnt <= 3'd0;
        end
      end else begin
        if (w_sck_rise) begin
          r_rx     <= w_byte[6:0];
          r_bitcnt <= w_bitcnt_next;
        end
        if (w_byte_done) begin
          case (r_state)
            ST_INSTR: begin
              if (w_byte == 8'h02) begin
                r_is_read <= 1'b0;
                r_state   <= ST_ADDR_H;
              end else if (w_byte == 8'h03) begin
                r_is_read <= 1'b1;
                r_state   <= ST_ADDR_H;
              end else begin
                r_state   <= ST_IGNORE;
              end
            end
            ST_ADDR_H: r_state <= ST_ADDR_L;
            ST_ADDR_L: begin
              r_state <= ST_DATA;
              if (r_is_read) begin
                r_tx   <= r_mem[w_frame_addr];
                r_addr <= w_frame_addr + ADDR_STEP;
              end else begin
                r_addr <= w_frame_addr;
              end
            end
            ST_DATA: begin
              if (r_is_read) begin
                r_tx <= r_mem[r_addr];
              end else begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_byte;
              end
              r_addr <= r_addr + ADDR_STEP;
            end
            default: ;
          endcase
        end
        if (w_sck_fall && r_state == ST_DATA && r_is_read) begin
          r_miso <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
        // A byte finishing in the same clk as CS rising has already been handled above.
        if (w_cs_rise) begin
          r_state     <= ST_IDLE;
          r_bitcnt    <= 3'd0;
          r_miso      <= 1'b0;
          r_frame_err <= (w_bitcnt_next != 3'd0);
        end
      end
    end
  end

  assign o_spi_miso  = r_miso & ~i_spi_cs;
  assign o_usr_rdata = r_usr_rdata;
  assign o_wr_valid  = r_wr_valid;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_frame_err = r_frame_err;

endmodule
